// File: rtl/park_pkg.sv
// Shared types and constants for the parking-space scan controller.
package park_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIGN   = 3'd1,
        MEASURE = 3'd2,
        SETTLE  = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5
    } park_state_t;

    localparam int H_MAX  = 800;
    localparam int V_MAX  = 525;
    localparam int VOTE_W = 4;

endpackage

// File: rtl/park_scan_ctrl_if.sv
// Bus between the scan controller and its environment (VGA timing, detector, steering).
interface park_scan_ctrl_if;
    import park_pkg::*;

    logic              start;
    logic              abort;
    logic [9:0]        HCnt;
    logic [9:0]        VCnt;
    logic              algo_done;
    logic              result;
    logic [3:0]        cfg_threshold;
    logic [3:0]        threshold;
    logic              algo_en;
    logic              busy;
    // Decision handshake: dec_valid rises with dec_space/dec_votes and all three hold
    // unchanged until the first cycle with dec_valid && dec_ready, when the transfer occurs.
    logic              dec_valid;
    logic              dec_ready;
    logic              dec_space;
    logic [VOTE_W-1:0] dec_votes;
    logic              timeout_err;

    modport master (
        output start, abort, HCnt, VCnt, algo_done, result, cfg_threshold, dec_ready,
        input  threshold, algo_en, busy, dec_valid, dec_space, dec_votes, timeout_err
    );

    modport slave (
        input  start, abort, HCnt, VCnt, algo_done, result, cfg_threshold, dec_ready,
        output threshold, algo_en, busy, dec_valid, dec_space, dec_votes, timeout_err
    );

endinterface

// File: rtl/park_vote.sv
// Positive-frame counter with majority comparator for one decision.
module park_vote
    import park_pkg::*;
#(
    parameter int VOTE_MIN = 3
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [VOTE_W-1:0] o_votes,
    output logic              o_dec_space
);

    logic [VOTE_W-1:0] r_votes;

    always_ff @(posedge clk25) begin
        if (reset || i_clr) begin
            r_votes <= '0;
        end else if (i_inc) begin
            r_votes <= r_votes + 1'b1;
        end
    end

    assign o_votes     = r_votes;
    assign o_dec_space = (r_votes >= VOTE_W'(VOTE_MIN));

endmodule

// File: rtl/park_scan_ctrl.sv
// Frame-aligned multi-frame scan sequencer with majority vote.
// Optional MEASURE timeout enabled by defining PARK_SCAN_TIMEOUT_EN.
module park_scan_ctrl
    import park_pkg::*;
#(
    parameter int NFRAMES      = 5,
    parameter int VOTE_MIN     = 3,
    parameter int TIMEOUT_LINE = 400
) (
    input  logic            clk25,
    input  logic            reset,
    park_scan_ctrl_if.slave bus,
    output park_state_t     o_state
);

`ifdef PARK_SCAN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    park_state_t       r_state;
    park_state_t       w_next;
    logic [3:0]        r_frame_cnt;
    logic              r_settle_cnt;
    logic [3:0]        r_threshold;
    logic              r_algo_en;
    logic              r_busy;
    logic              r_dec_valid;
    logic              r_dec_space;
    logic [VOTE_W-1:0] r_dec_votes;
    logic              r_timeout_err;

    logic              w_frame_start;
    logic              w_start_go;
    logic              w_sample;
    logic              w_timeout;
    logic              w_frame_last;
    logic [VOTE_W-1:0] w_votes;
    logic              w_space;

    assign w_frame_start = (bus.HCnt == 10'd0) && (bus.VCnt == 10'd0);
    assign w_start_go    = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_sample      = (r_state == SETTLE) && r_settle_cnt;
    assign w_timeout     = TIMEOUT_EN && (r_state == MEASURE) && !bus.algo_done &&
                           (bus.VCnt == 10'(TIMEOUT_LINE));
    assign w_frame_last  = ((r_frame_cnt + 4'd1) == 4'(NFRAMES));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = ALIGN;
            ALIGN:   if (w_frame_start) w_next = MEASURE;
            MEASURE: begin
                if (bus.algo_done)  w_next = SETTLE;
                else if (w_timeout) w_next = NEXT;
            end
            SETTLE:  if (r_settle_cnt) w_next = NEXT;
            NEXT:    w_next = w_frame_last ? DONE : ALIGN;
            DONE:    if (r_dec_valid && bus.dec_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.abort) w_next = IDLE;
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_state       <= IDLE;
            r_frame_cnt   <= '0;
            r_settle_cnt  <= 1'b0;
            r_threshold   <= '0;
            r_algo_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_dec_valid   <= 1'b0;
            r_dec_space   <= 1'b0;
            r_dec_votes   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_algo_en    <= (w_next == MEASURE) || (w_next == SETTLE);
            r_busy       <= (w_next != IDLE);
            r_dec_valid  <= (w_next == DONE);
            r_settle_cnt <= (r_state == SETTLE) && (w_next == SETTLE);

            if (w_next != DONE) begin
                r_dec_space <= 1'b0;
                r_dec_votes <= '0;
            end else if (r_state != DONE) begin
                r_dec_space <= w_space;
                r_dec_votes <= w_votes;
            end

            if (w_start_go) begin
                r_frame_cnt   <= '0;
                r_threshold   <= bus.cfg_threshold;
                r_timeout_err <= 1'b0;
            end else begin
                if (r_state == NEXT) r_frame_cnt <= r_frame_cnt + 4'd1;
                if (w_timeout && !bus.abort) r_timeout_err <= 1'b1;
            end
        end
    end

    park_vote #(.VOTE_MIN(VOTE_MIN)) u_vote (
        .clk25       (clk25),
        .reset       (reset),
        .i_clr       (w_start_go),
        .i_inc       (w_sample && bus.result && !bus.abort),
        .o_votes     (w_votes),
        .o_dec_space (w_space)
    );

    assign bus.threshold   = r_threshold;
    assign bus.algo_en     = r_algo_en;
    assign bus.busy        = r_busy;
    assign bus.dec_valid   = r_dec_valid;
    assign bus.dec_space   = r_dec_space;
    assign bus.dec_votes   = r_dec_votes;
    assign bus.timeout_err = r_timeout_err;
    assign o_state         = r_state;

endmodule

// File: tb/tb_park_scan_ctrl.sv
// Bench for park_scan_ctrl: compressed raster (2 pixels per line), detector model, decision scoreboard.
module tb_park_scan_ctrl;
    import park_pkg::*;

    localparam int NF        = 5;
    localparam int VMIN      = 3;
    localparam int TO_LINE   = 400;
    localparam int TB_H      = 2;
    localparam int FRAME     = TB_H * V_MAX;
    localparam int DONE_LINE = 200;

    logic clk25 = 1'b0;
    logic reset;
    always #5 clk25 = ~clk25;

    park_scan_ctrl_if bus();
    park_state_t      dbg_state;

    park_scan_ctrl #(.NFRAMES(NF), .VOTE_MIN(VMIN), .TIMEOUT_LINE(TO_LINE)) dut (
        .clk25   (clk25),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [5:0]  exp_q[$];
    logic [15:0] pat = '0;
    logic [15:0] sup = '0;
    int          m_idx = 0;
    int          rise_cnt = 0;
    logic [9:0]  rise_h = '0;
    logic [9:0]  rise_v = '0;
    logic [9:0]  fall_v[16];
    logic        en_prev = 1'b0;
    logic        dv_prev = 1'b0;
    logic [3:0]  exp_thr = '0;

    // Raster generator and detector model: done at DONE_LINE, result from pat, frames in sup never finish.
    initial begin
        bus.HCnt = '0;
        bus.VCnt = '0;
        bus.algo_done = 1'b0;
        bus.result = 1'b0;
        for (int i = 0; i < 16; i++) fall_v[i] = '0;
        forever begin
            @(negedge clk25);
            if (bus.algo_en && !en_prev) begin
                rise_h = bus.HCnt;
                rise_v = bus.VCnt;
                rise_cnt++;
            end
            if (!bus.algo_en && en_prev) begin
                if (m_idx < 16) fall_v[m_idx] = bus.VCnt;
                m_idx++;
            end
            if (!bus.algo_en) begin
                bus.algo_done = 1'b0;
                bus.result = 1'b0;
            end else if (bus.VCnt == 10'(DONE_LINE) && bus.HCnt == 10'd0 && m_idx < 16 && !sup[m_idx]) begin
                bus.algo_done = 1'b1;
                bus.result = pat[m_idx];
            end
            en_prev = bus.algo_en;
            if (bus.HCnt == 10'(TB_H - 1)) begin
                bus.HCnt = '0;
                bus.VCnt = (bus.VCnt == 10'(V_MAX - 1)) ? 10'd0 : bus.VCnt + 10'd1;
            end else begin
                bus.HCnt = bus.HCnt + 10'd1;
            end
        end
    end

    // Scoreboard: each new decision pops one expected {timeout_err, dec_space, dec_votes}.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk25);
            if (bus.dec_valid && !dv_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_decision: got dec_valid=1 votes=%0d, required no decision", bus.dec_votes);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (bus.dec_votes !== e[3:0]) begin
                        n_err++;
                        $display("FAIL dec_votes: got %0d, required %0d", bus.dec_votes, e[3:0]);
                    end
                    n_cmp++;
                    if (bus.dec_space !== e[4]) begin
                        n_err++;
                        $display("FAIL dec_space: got %0b, required %0b", bus.dec_space, e[4]);
                    end
                    n_cmp++;
                    if (bus.timeout_err !== e[5]) begin
                        n_err++;
                        $display("FAIL timeout_err: got %0b, required %0b", bus.timeout_err, e[5]);
                    end
                end
            end
            dv_prev = bus.dec_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic drive_start(input logic [15:0] p, input logic [15:0] s, input bit push);
        int v;
        logic [3:0] thr;
        v = 0;
        for (int i = 0; i < NF; i++) if (p[i] && !s[i]) v++;
        if (push) exp_q.push_back({(s[NF-1:0] != '0), (v >= VMIN), 4'(v)});
        pat = p;
        sup = s;
        m_idx = 0;
        thr = 4'($urandom_range(0, 15));
        bus.cfg_threshold = thr;
        exp_thr = thr;
        bus.start = 1'b1;
        @(negedge clk25);
        bus.start = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk25);
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.cfg_threshold = 4'hF;
        reset = 1'b1;
        step(3);
        n_cmp++;
        if ({bus.algo_en, bus.busy, bus.dec_valid, bus.dec_space, bus.dec_votes, bus.timeout_err, bus.threshold} !== 13'd0
            || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_values: got outs=%b state=%0d, required all 0 and IDLE",
                     {bus.algo_en, bus.busy, bus.dec_valid, bus.dec_space, bus.dec_votes, bus.timeout_err, bus.threshold}, dbg_state);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step(2);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.algo_en !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got busy=%0b algo_en=%0b, required 0 0", bus.busy, bus.algo_en);
        end
    endtask

    task automatic test_vote(input logic [15:0] p, input string name);
        bit ok;
        drive_start(p, 16'd0, 1'b1);
        n_cmp++;
        if (bus.threshold !== exp_thr) begin
            n_err++;
            $display("FAIL %s threshold: got %0d, required %0d", name, bus.threshold, exp_thr);
        end
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %0b, required 1", name, bus.busy);
        end
        wait_quiet(7 * FRAME, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s decision_timeout: got no decision in %0d cycles, required one", name, 7 * FRAME);
        end
    endtask

    task automatic test_align();
        bit ok;
        bit hit;
        int r0;
        hit = 1'b0;
        for (int i = 0; i < FRAME && !hit; i++) begin
            @(negedge clk25);
            if (bus.VCnt == 10'd300) hit = 1'b1;
        end
        r0 = rise_cnt;
        drive_start(16'h001F, 16'd0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk25);
            if (rise_cnt != r0) hit = 1'b1;
        end
        n_cmp++;
        if (!hit || rise_h !== 10'd0 || rise_v !== 10'd0) begin
            n_err++;
            $display("FAIL align_rise: got risen=%0b at H=%0d V=%0d, required rise right after H=0 V=0", hit, rise_h, rise_v);
        end
        wait_quiet(7 * FRAME, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL align decision_timeout: got none, required one");
        end
    endtask

    task automatic test_back_to_back();
        bit hit;
        bus.dec_ready = 1'b0;
        drive_start(16'h000D, 16'd0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 7 * FRAME && !hit; i++) begin
            @(negedge clk25);
            if (bus.dec_valid) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL hold decision_timeout: got none, required dec_valid");
        end
        for (int i = 0; i < 100; i++) begin
            step(1);
            n_cmp++;
            if (bus.dec_valid !== 1'b1 || bus.dec_space !== 1'b1 || bus.dec_votes !== 4'd3) begin
                n_err++;
                $display("FAIL hold_stable cycle %0d: got v=%0b s=%0b n=%0d, required 1 1 3",
                         i, bus.dec_valid, bus.dec_space, bus.dec_votes);
            end
        end
        bus.dec_ready = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.dec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL accept_idle: got busy=%0b dec_valid=%0b, required 0 0", bus.busy, bus.dec_valid);
        end
        step(3);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_on_accept_ignored: got busy=%0b, required 0", bus.busy);
        end
    endtask

`ifdef PARK_SCAN_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        fall_v[2] = '0;
        drive_start(16'h001F, 16'h0004, 1'b1);
        wait_quiet(7 * FRAME, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL timeout decision_timeout: got none, required one");
        end
        n_cmp++;
        if (fall_v[2] !== 10'(TO_LINE)) begin
            n_err++;
            $display("FAIL timeout_fall_line: got V=%0d, required %0d", fall_v[2], TO_LINE);
        end
        n_cmp++;
        if (bus.timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: got %0b, required 1", bus.timeout_err);
        end
    endtask
`endif

    task automatic test_abort();
        bit hit;
        drive_start(16'h001F, 16'd0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            @(negedge clk25);
            if (m_idx == 1 && bus.algo_en && bus.VCnt >= 10'd50 && bus.VCnt < 10'd150) hit = 1'b1;
        end
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        n_cmp++;
        if (!hit || bus.algo_en !== 1'b0 || bus.busy !== 1'b0 || bus.dec_valid !== 1'b0 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL abort_measure: got reached=%0b en=%0b busy=%0b dv=%0b state=%0d, required 1 0 0 0 IDLE",
                     hit, bus.algo_en, bus.busy, bus.dec_valid, dbg_state);
        end
        step(FRAME);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.algo_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_stays_idle: got busy=%0b en=%0b, required 0 0", bus.busy, bus.algo_en);
        end
    endtask

    task automatic test_reset_settle();
        bit hit;
        drive_start(16'h001F, 16'd0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk25);
            if (dbg_state == SETTLE) hit = 1'b1;
        end
        reset = 1'b1;
        step(1);
        n_cmp++;
        if (!hit || dbg_state !== IDLE ||
            {bus.algo_en, bus.busy, bus.dec_valid, bus.dec_space, bus.dec_votes, bus.timeout_err, bus.threshold} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_settle: got reached=%0b state=%0d outs=%b, required 1 IDLE all 0", hit, dbg_state,
                     {bus.algo_en, bus.busy, bus.dec_valid, bus.dec_space, bus.dec_votes, bus.timeout_err, bus.threshold});
        end
        reset = 1'b0;
        exp_thr = '0;
        step(FRAME);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_settle_idle: got busy=%0b, required 0", bus.busy);
        end
    endtask

    task automatic test_start_abort();
        bus.cfg_threshold = exp_thr ^ 4'hF;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.threshold !== exp_thr) begin
            n_err++;
            $display("FAIL start_abort: got busy=%0b thr=%0d, required 0 %0d", bus.busy, bus.threshold, exp_thr);
        end
        step(5);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.algo_en !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_idle: got busy=%0b en=%0b, required 0 0", bus.busy, bus.algo_en);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_threshold = '0;
        bus.dec_ready = 1'b1;
        test_reset();
        test_vote(16'h0017, "vote_4of5");
        test_vote(16'h000A, "vote_2of5");
        test_vote(16'h001C, "vote_3of5_min");
        test_vote(16'($urandom_range(0, 31)), "vote_random");
        test_align();
        test_back_to_back();
`ifdef PARK_SCAN_TIMEOUT_EN
        test_timeout();
`endif
        test_abort();
        test_reset_settle();
        test_start_abort();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_decisions: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by 200000 cycles, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
